// File: rtl/multicycle_addsub.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock, with a start/done handshake.
// Optional output saturation on signed overflow when ADDER_SATURATE_EN is defined.
module multicycle_addsub #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned CHUNK = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Mode,
  input  logic [WIDTH-1:0] SRC1,
  input  logic [WIDTH-1:0] SRC2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Output,
  output logic             Carry,
  output logic             Overflow,
  output logic             Zero,
  output logic             Negative
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             c_reg;
  logic [WIDTH-1:0] sum_reg;

  logic [CHUNK-1:0] a_chunk_c;
  logic [CHUNK-1:0] b_chunk_c;
  logic [CHUNK:0]   csum_c;
  logic [WIDTH-1:0] sum_c;
  logic             ovf_c;
  logic [WIDTH-1:0] res_c;

  // Select the active chunk, add it with the registered carry, and merge into the partial sum.
  always_comb begin
    a_chunk_c = '0;
    b_chunk_c = '0;
    for (int i = 0; i < int'(NCHUNK); i++) begin
      if (cnt == CW'(i)) begin
        a_chunk_c = a_reg[i*CHUNK +: CHUNK];
        b_chunk_c = b_reg[i*CHUNK +: CHUNK];
      end
    end
    csum_c = {1'b0, a_chunk_c} + {1'b0, b_chunk_c} + (CHUNK+1)'(c_reg);
    sum_c  = sum_reg;
    for (int i = 0; i < int'(NCHUNK); i++) begin
      if (cnt == CW'(i)) begin
        sum_c[i*CHUNK +: CHUNK] = csum_c[CHUNK-1:0];
      end
    end
    ovf_c = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum_c[WIDTH-1] != a_reg[WIDTH-1]);
`ifdef ADDER_SATURATE_EN
    if (ovf_c) begin
      res_c = a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res_c = sum_c;
    end
`else
    res_c = sum_c;
`endif
  end

  // Handshake FSM; Output and flags are written only on the final-chunk edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      c_reg    <= 1'b0;
      sum_reg  <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      Output   <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
      Zero     <= 1'b1;
      Negative <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= SRC1;
            b_reg   <= Mode ? ~SRC2 : SRC2;
            c_reg   <= Mode;
            cnt     <= '0;
            sum_reg <= '0;
            ready   <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_reg <= sum_c;
          c_reg   <= csum_c[CHUNK];
          if (cnt == LAST) begin
            Output   <= res_c;
            Carry    <= csum_c[CHUNK];
            Overflow <= ovf_c;
            Zero     <= (res_c == '0);
            Negative <= res_c[WIDTH-1];
            done     <= 1'b1;
            ready    <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_addsub.sv
// Randomized and directed self-checking bench for multicycle_addsub against an arithmetic model.
module tb_multicycle_addsub;

  localparam int unsigned W      = 18;
  localparam int unsigned LAT    = 3;
  localparam int unsigned BUDGET = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         Mode;
  logic [W-1:0] SRC1;
  logic [W-1:0] SRC2;
  logic         ready;
  logic         done;
  logic [W-1:0] Output;
  logic         Carry;
  logic         Overflow;
  logic         Zero;
  logic         Negative;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_addsub dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .Mode     (Mode),
    .SRC1     (SRC1),
    .SRC2     (SRC2),
    .ready    (ready),
    .done     (done),
    .Output   (Output),
    .Carry    (Carry),
    .Overflow (Overflow),
    .Zero     (Zero),
    .Negative (Negative)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                       output logic [W-1:0] res, output logic c, output logic v,
                       output logic z, output logic n);
    longint ua, ub, full, sa, sb, sr;
    ua = longint'(a);
    ub = longint'(b);
    full = m ? (ua + ((longint'(1) << W) - 1 - ub) + 1) : (ua + ub);
    c  = full[W];
    res = full[W-1:0];
    sa = (ua >= (longint'(1) << (W-1))) ? ua - (longint'(1) << W) : ua;
    sb = (ub >= (longint'(1) << (W-1))) ? ub - (longint'(1) << W) : ub;
    sr = m ? sa - sb : sa + sb;
    v  = (sr > (longint'(1) << (W-1)) - 1) || (sr < -(longint'(1) << (W-1)));
`ifdef ADDER_SATURATE_EN
    if (v) res = (sr > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    z = (res == '0);
    n = res[W-1];
  endtask

  // Issue one operation from the current (ready) cycle and check latency and results.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input logic busy_pulse);
    logic [W-1:0] er;
    logic ec, ev, ez, en;
    int cyc;
    model(a, b, m, er, ec, ev, ez, en);
    check("ready_before", 32'(ready), 32'd1);
    SRC1 = a; SRC2 = b; Mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (1) begin
      SRC1 = W'($urandom); SRC2 = W'($urandom); Mode = 1'($urandom);
      start = busy_pulse && (cyc == 0);
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (done === 1'b1) break;
      if (cyc >= int'(BUDGET)) begin
        check("done_timeout", 32'(cyc), 32'(LAT));
        return;
      end
      check("ready_busy", 32'(ready), 32'd0);
      check("output_hold", 32'(Output === er && cyc < 0), 32'd0);
    end
    check("latency", 32'(cyc), 32'(LAT));
    check("ready_done", 32'(ready), 32'd1);
    check("output", 32'(Output), 32'(er));
    check("carry", 32'(Carry), 32'(ec));
    check("overflow", 32'(Overflow), 32'(ev));
    check("zero", 32'(Zero), 32'(ez));
    check("negative", 32'(Negative), 32'(en));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_output"}, 32'(Output), 32'd0);
    check({tag, "_flags"}, {28'd0, Carry, Overflow, Zero, Negative}, 32'b0010);
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    rst = 1'b1; start = 1'b0; Mode = 1'b0; SRC1 = '0; SRC2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(18'd123, 18'd456, 1'b0, 1'b0);
    check("add_const", 32'(Output), 32'h00243);
    check("add_flags", {28'd0, Carry, Overflow, Zero, Negative}, 32'b0000);

    run_op(18'h0003F, 18'h00001, 1'b0, 1'b0);
    check("chunk_carry", 32'(Output), 32'h00040);
    check("chunk_carry_c", 32'(Carry), 32'd0);
    run_op(18'h3FFFF, 18'h00001, 1'b0, 1'b0);
    check("wrap", {Output, Carry, Zero, Overflow}, {18'h0, 1'b1, 1'b1, 1'b0});

    run_op(18'h20000, 18'h3FFFF, 1'b0, 1'b0);
    check("sovf_vc", {30'd0, Overflow, Carry}, 32'b11);
`ifdef ADDER_SATURATE_EN
    check("sovf_out", {Output, Negative}, {18'h20000, 1'b1});
`else
    check("sovf_out", {Output, Negative}, {18'h1FFFF, 1'b0});
`endif

    run_op(18'd5, 18'd7, 1'b1, 1'b0);
    check("sub_neg", {Output, Carry, Negative}, {18'h3FFFE, 1'b0, 1'b1});
    run_op(18'd7, 18'd7, 1'b1, 1'b0);
    check("sub_zero", {Output, Zero, Carry}, {18'h0, 1'b1, 1'b1});

    // start pulsed while busy must be ignored
    run_op(18'h1FFFF, 18'h00001, 1'b0, 1'b1);
    expect_no_done("busy_start_ignored", 6);

    // back-to-back: each run_op starts in the previous done cycle
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i % 8 == 1) a = 18'h1FFFF;
      if (i % 8 == 2) b = 18'h20000;
      if (i % 8 == 3) b = a;
      run_op(a, b, 1'($urandom), 1'(i % 5 == 0));
    end

    // reset mid-operation aborts with no done
    SRC1 = 18'h12345; SRC2 = 18'h01111; Mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("midrun_reset");
    rst = 1'b0;
    expect_no_done("midrun_no_done", 6);
    run_op(18'd100, 18'd200, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
